// File: rtl/uart_rx.sv
// uart_rx
//   8N1 UART receiver. It is clocked by clk and advances its bit timing only
//   on baudEn strobes, which arrive at OVERSAMPLE times the bit rate. rxd is
//   synchronised, the start bit is confirmed at its centre, and the data and
//   stop bits are sampled at their centres.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   baudEn     in   one-clk strobe at OVERSAMPLE x bit rate
//   rxd        in   asynchronous serial input, idle high
//   rxData     out  last good byte (held until the next good frame)
//   rxValid    out  one-clk pulse when rxData is updated
//   rxFrameErr out  one-clk pulse when the stop bit is sampled low
//   rxBusy     out  high whenever the receiver is not idle
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baudEn,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid,
  output logic                 rxFrameErr,
  output logic                 rxBusy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'((OVERSAMPLE / 32'sd2) - 32'sd1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 32'sd1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(32'sd1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 32'sd1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(32'sd1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   rx_meta_r;
  logic                   rxs_r;
  logic [TICK_W-1:0]      tick_r;
  logic [TICK_W-1:0]      tick_nxt_s;
  logic [BIT_W-1:0]       bit_r;
  logic [BIT_W-1:0]       bit_nxt_s;
  logic [DATA_BITS-1:0]   shift_r;
  logic [DATA_BITS-1:0]   shift_nxt_s;
  logic [DATA_BITS-1:0]   data_nxt_s;
  logic                   valid_nxt_s;
  logic                   ferr_nxt_s;

  // Two-flop synchroniser for the asynchronous pin; resets to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= rxd;
      rxs_r     <= rx_meta_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; nothing moves on cycles without a baud tick.
  always_comb begin
    state_nxt_s = state_r;
    if (baudEn) begin
      case (state_r)
        IDLE: begin
          if (!rxs_r) state_nxt_s = START;
          else        state_nxt_s = IDLE;
        end
        START: begin
          // Mid-start check: a high line here was only a glitch.
          if (tick_r == TICK_MID) state_nxt_s = rxs_r ? IDLE : DATA;
          else                    state_nxt_s = START;
        end
        DATA: begin
          if ((tick_r == TICK_LAST) && (bit_r == BIT_LAST)) state_nxt_s = STOP;
          else                                              state_nxt_s = DATA;
        end
        STOP: begin
          if (tick_r == TICK_LAST) state_nxt_s = rxs_r ? IDLE : BREAK;
          else                     state_nxt_s = STOP;
        end
        BREAK: begin
          // A line held low after a bad stop must return high before a new frame.
          if (rxs_r) state_nxt_s = IDLE;
          else       state_nxt_s = BREAK;
        end
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output/datapath logic: counters, shift register and the strobes.
  always_comb begin
    tick_nxt_s  = tick_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    data_nxt_s  = rxData;
    valid_nxt_s = 1'b0;
    ferr_nxt_s  = 1'b0;
    if (baudEn) begin
      case (state_r)
        IDLE: begin
          tick_nxt_s = '0;
          bit_nxt_s  = '0;
        end
        START: begin
          if (tick_r == TICK_MID) begin
            tick_nxt_s = '0;
            bit_nxt_s  = '0;
          end else begin
            tick_nxt_s = tick_r + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_r == TICK_LAST) begin
            // LSB arrives first, so new bits enter at the top and move down.
            shift_nxt_s                = shift_r >> 1;
            shift_nxt_s[DATA_BITS-1]   = rxs_r;
            tick_nxt_s                 = '0;
            bit_nxt_s                  = bit_r + BIT_ONE;
          end else begin
            tick_nxt_s = tick_r + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_r == TICK_LAST) begin
            tick_nxt_s = '0;
            if (rxs_r) begin
              data_nxt_s  = shift_r;
              valid_nxt_s = 1'b1;
            end else begin
              ferr_nxt_s  = 1'b1;
            end
          end else begin
            tick_nxt_s = tick_r + TICK_ONE;
          end
        end
        BREAK: begin
          tick_nxt_s = '0;
        end
        default: begin
          tick_nxt_s = '0;
          bit_nxt_s  = '0;
        end
      endcase
    end else begin
      tick_nxt_s = tick_r;
    end
  end

  // Datapath and output registers; busy tracks the state being entered so it
  // drops in the same clk that rxValid rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r     <= '0;
      bit_r      <= '0;
      shift_r    <= '0;
      rxData     <= '0;
      rxValid    <= 1'b0;
      rxFrameErr <= 1'b0;
      rxBusy     <= 1'b0;
    end else begin
      tick_r     <= tick_nxt_s;
      bit_r      <= bit_nxt_s;
      shift_r    <= shift_nxt_s;
      rxData     <= data_nxt_s;
      rxValid    <= valid_nxt_s;
      rxFrameErr <= ferr_nxt_s;
      rxBusy     <= (state_nxt_s != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Self-checking bench for uart_rx. Frames are driven bit by bit on the pin
//   with the clk timing of a real line (one bit = OVERSAMPLE baud ticks), and
//   a model queue holds what a correct receiver must report for each frame.
module tb_uart_rx;
  localparam int DB        = 8;
  localparam int OS        = 16;
  localparam int TICK_CLKS = 4;
  localparam int BIT_CLKS  = OS * TICK_CLKS;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       baud_raw = 1'b0;
  logic       baud_hold = 1'b0;
  logic       baudEn;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxFrameErr;
  logic       rxBusy;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         strobe_cnt = 0;
  exp_t       exp_q[$];
  int         valid_times[$];
  logic [7:0] last_good = 8'h00;

  assign baudEn = baud_raw & ~baud_hold;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .baudEn(baudEn), .rxd(rxd),
    .rxData(rxData), .rxValid(rxValid), .rxFrameErr(rxFrameErr), .rxBusy(rxBusy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Free-running baud generator: one strobe every TICK_CLKS clks.
  initial begin : baud_gen
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      baud_raw = (cnt == 0);
      cnt = (cnt + 1) % TICK_CLKS;
    end
  end

  // Monitor: every strobe must match the next expected frame outcome.
  initial begin : monitor
    exp_t e;
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rxValid || rxFrameErr) begin
        strobe_cnt++;
        chk("strobe_excl", 32'(rxValid & rxFrameErr), 32'd0);
        chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("strobe_kind", 32'(rxFrameErr), 32'(e.ferr));
          if (rxValid) begin
            chk("rxData", 32'(rxData), 32'(e.data));
            last_good = e.data;
            valid_times.push_back(cyc);
            chk("busy_fall", 32'({prev_busy, rxBusy}), 32'd2);
          end else begin
            chk("ferr_data_hold", 32'(rxData), 32'(last_good));
          end
        end
      end
      prev_busy = rxBusy;
    end
  end

  task automatic idle_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  // Freeze the baud strobe for 200 clks and confirm nothing observable moves.
  task automatic hold_baud();
    logic [7:0] snap_data;
    int         snap_cnt;
    snap_data = rxData;
    snap_cnt  = strobe_cnt;
    baud_hold = 1'b1;
    chk("hold_busy_pre", 32'(rxBusy), 32'd1);
    repeat (200) @(negedge clk);
    chk("hold_busy_post", 32'(rxBusy), 32'd1);
    chk("hold_data", 32'(rxData), 32'(snap_data));
    chk("hold_nostrobe", 32'(strobe_cnt), 32'(snap_cnt));
    baud_hold = 1'b0;
  endtask

  // Drive one frame; hold_bit >= 0 stretches that bit by the baud freeze.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit expect_it, input int hold_bit);
    exp_t e;
    if (expect_it) begin
      e.ferr = !stop_ok;
      e.data = b;
      exp_q.push_back(e);
    end
    for (int k = 0; k < DB + 2; k++) begin
      if (k == 0)           rxd = 1'b0;
      else if (k == DB + 1) rxd = stop_ok;
      else                  rxd = b[k-1];
      if (k == hold_bit) begin
        repeat (BIT_CLKS / 2) @(negedge clk);
        hold_baud();
        repeat (BIT_CLKS / 2) @(negedge clk);
      end else begin
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
    if (stop_ok) rxd = 1'b1;
  endtask

  task automatic drained(input string tag);
    chk(tag, 32'(exp_q.size()), 32'd0);
    chk("rxData_hold", 32'(rxData), 32'(last_good));
  endtask

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : main
    int         vt0;
    int         fall_at;
    bit         saw;
    logic [7:0] b;
    bit         ok;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(rxData), 32'd0);
    chk("rst_valid", 32'(rxValid), 32'd0);
    chk("rst_ferr",  32'(rxFrameErr), 32'd0);
    chk("rst_busy",  32'(rxBusy), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // 1: single frame
    send_frame(8'h55, 1'b1, 1'b1, -1);
    idle_bits(2);
    drained("t1_drain");

    // 2: back-to-back frames, no idle gap
    vt0 = valid_times.size();
    send_frame(8'hA3, 1'b1, 1'b1, -1);
    send_frame(8'h0F, 1'b1, 1'b1, -1);
    idle_bits(2);
    drained("t2_drain");
    chk("b2b_count", 32'(valid_times.size() - vt0), 32'd2);
    if (valid_times.size() - vt0 == 2)
      chk("b2b_gap", 32'(valid_times[vt0+1] - valid_times[vt0]), 32'd640);

    // 3: short low glitch must be rejected at mid-start
    saw = 1'b0;
    fall_at = -1;
    rxd = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 12) rxd = 1'b1;
      @(negedge clk);
      if (rxBusy) saw = 1'b1;
      else if (saw && fall_at < 0) fall_at = i;
    end
    chk("glitch_busy_rose", 32'(saw), 32'd1);
    chk("glitch_busy_fell", 32'(rxBusy), 32'd0);
    chk("glitch_fall_time", 32'(fall_at >= 32 && fall_at <= 42), 32'd1);
    drained("t3_drain");

    // 4: framing error, line held low, then a good frame
    send_frame(8'h81, 1'b0, 1'b1, -1);
    for (int i = 0; i < 3; i++) begin
      idle_bits(1);
      chk("break_busy", 32'(rxBusy), 32'd1);
    end
    rxd = 1'b1;
    idle_bits(1);
    chk("break_exit", 32'(rxBusy), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    idle_bits(2);
    drained("t4_drain");

    // 5: reset during data bit 4; the tail (bits 4..7 high) must stay silent
    b = {4'hF, 4'($urandom_range(0, 15))};
    fork
      send_frame(b, 1'b1, 1'b0, -1);
      begin
        repeat (BIT_CLKS * 5 + BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_data",  32'(rxData), 32'd0);
        chk("mid_rst_valid", 32'(rxValid), 32'd0);
        chk("mid_rst_ferr",  32'(rxFrameErr), 32'd0);
        chk("mid_rst_busy",  32'(rxBusy), 32'd0);
        last_good = 8'h00;
      end
    join
    send_frame(8'hC6, 1'b1, 1'b1, -1);
    idle_bits(2);
    drained("t5_drain");

    // 6: baud freeze in the middle of data bit 2
    send_frame(8'($urandom), 1'b1, 1'b1, 3);
    idle_bits(2);
    drained("t6_drain");

    // Random frames: random data, occasional bad stop, random gaps and phase
    for (int n = 0; n < 20; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(b, ok, 1'b1, -1);
      if (!ok) begin
        repeat ($urandom_range(0, 2) * BIT_CLKS) @(negedge clk);
        rxd = 1'b1;
        idle_bits(1);
      end else begin
        repeat ($urandom_range(0, 1) * $urandom_range(0, BIT_CLKS)) @(negedge clk);
      end
    end
    idle_bits(2);
    drained("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
